// File: rtl/tanque_sensor_emulador.sv
// Water tank emulator with three level probes (H, M, L).
// The internal level moves once per prescaled tick: it fills by FILL_STEP while
// Ve is open and drains by DRAIN_STEP while Dreno is active, saturating at
// 0 and MAX_LEVEL. The probes switch on at their thresholds and only switch
// off HYST below them. Fault injection overrides the probe outputs
// combinationally so the downstream decoder sees its error patterns.
module tanque_sensor_emulador #(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned MAX_LEVEL  = 255,
    parameter int unsigned INIT_LEVEL = 0,
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned FILL_STEP  = 2,
    parameter int unsigned DRAIN_STEP = 1,
    parameter int unsigned L_TH       = 64,
    parameter int unsigned M_TH       = 128,
    parameter int unsigned H_TH       = 192,
    parameter int unsigned HYST       = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Ve,
    input  logic               Dreno,
    input  logic [1:0]         Fault_Sel,
    input  logic               Clr_Flags,
    output logic [LEVEL_W-1:0] Level,
    output logic               H,
    output logic               M,
    output logic               L,
    output logic               Tick,
    output logic               Overflow,
    output logic               Seco
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SUM_W = LEVEL_W + 2;

    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0]        LVL_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0]        LVL_INIT = LEVEL_W'(INIT_LEVEL);
    localparam logic signed [SUM_W-1:0]   SUM_MAX  = SUM_W'(MAX_LEVEL);
    localparam logic signed [SUM_W-1:0]   SUM_FILL = SUM_W'(FILL_STEP);
    localparam logic signed [SUM_W-1:0]   SUM_DRN  = SUM_W'(DRAIN_STEP);

    localparam logic [LEVEL_W-1:0] L_ON  = LEVEL_W'(L_TH);
    localparam logic [LEVEL_W-1:0] L_OFF = LEVEL_W'(L_TH - HYST);
    localparam logic [LEVEL_W-1:0] M_ON  = LEVEL_W'(M_TH);
    localparam logic [LEVEL_W-1:0] M_OFF = LEVEL_W'(M_TH - HYST);
    localparam logic [LEVEL_W-1:0] H_ON  = LEVEL_W'(H_TH);
    localparam logic [LEVEL_W-1:0] H_OFF = LEVEL_W'(H_TH - HYST);

    logic [CNT_W-1:0]        presc_q, presc_d;
    logic [LEVEL_W-1:0]      level_q, level_d;
    logic                    sh_q, sh_d;
    logic                    sm_q, sm_d;
    logic                    sl_q, sl_d;
    logic                    tick_q, tick_d;
    logic                    ovf_q, ovf_d;
    logic                    seco_q, seco_d;
    logic                    wrap;
    logic signed [SUM_W-1:0] sum;

    // Probe with hysteresis: on at/above the threshold, off below threshold-HYST, else hold.
    function automatic logic probeNext(input logic [LEVEL_W-1:0] lvl,
                                       input logic [LEVEL_W-1:0] onTh,
                                       input logic [LEVEL_W-1:0] offTh,
                                       input logic               cur);
        logic res;
        res = cur;
        if (lvl >= onTh) begin
            res = 1'b1;
        end else if (lvl < offTh) begin
            res = 1'b0;
        end
        return res;
    endfunction

    // Prescaler, saturating level update, sticky flags and probe next-state.
    always_comb begin
        presc_d = presc_q;
        level_d = level_q;
        tick_d  = 1'b0;
        ovf_d   = ovf_q;
        seco_d  = seco_q;
        wrap    = (presc_q == CNT_LAST);
        sum     = signed'(SUM_W'(level_q))
                + (Ve    ? SUM_FILL : '0)
                - (Dreno ? SUM_DRN  : '0);

        if (Clr_Flags) begin
            ovf_d  = 1'b0;
            seco_d = 1'b0;
        end

        if (wrap) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sum < 0) begin
                level_d = '0;
            end else if (sum > SUM_MAX) begin
                level_d = LVL_MAX;
            end else begin
                level_d = sum[LEVEL_W-1:0];
            end
            if (Ve && (level_q == LVL_MAX)) begin
                ovf_d = 1'b1;
            end
            if (Dreno && (level_q == '0)) begin
                seco_d = 1'b1;
            end
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end

        sh_d = probeNext(level_q, H_ON, H_OFF, sh_q);
        sm_d = probeNext(level_q, M_ON, M_OFF, sm_q);
        sl_d = probeNext(level_q, L_ON, L_OFF, sl_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            presc_q <= '0;
            level_q <= LVL_INIT;
            sh_q    <= 1'b0;
            sm_q    <= 1'b0;
            sl_q    <= 1'b0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
            seco_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            level_q <= level_d;
            sh_q    <= sh_d;
            sm_q    <= sm_d;
            sl_q    <= sl_d;
            tick_q  <= tick_d;
            ovf_q   <= ovf_d;
            seco_q  <= seco_d;
        end
    end

    // Fault override on the probe outputs; the probe registers themselves are untouched.
    always_comb begin
        H = sh_q;
        M = sm_q;
        L = sl_q;
        unique case (Fault_Sel)
            2'b01:   M = 1'b0;
            2'b10:   H = 1'b1;
            2'b11:   L = 1'b0;
            default: ;
        endcase
    end

    assign Level    = level_q;
    assign Tick     = tick_q;
    assign Overflow = ovf_q;
    assign Seco     = seco_q;

endmodule

// File: tb/tb_tanque_sensor_emulador.sv
// Self-checking bench for tanque_sensor_emulador with a fast prescaler.
// A behavioural tank model tracks the expected level, probes and flags from
// the number of clock edges since reset and plain integer arithmetic.
module tb_tanque_sensor_emulador;

    localparam int LEVEL_W    = 8;
    localparam int MAX_LEVEL  = 255;
    localparam int INIT_LEVEL = 0;
    localparam int TICK_DIV   = 4;
    localparam int FILL_STEP  = 2;
    localparam int DRAIN_STEP = 1;
    localparam int L_TH       = 64;
    localparam int M_TH       = 128;
    localparam int H_TH       = 192;
    localparam int HYST       = 8;

    logic               Clk = 1'b0;
    logic               Rst_n;
    logic               Ve;
    logic               Dreno;
    logic [1:0]         Fault_Sel;
    logic               Clr_Flags;
    logic [LEVEL_W-1:0] Level;
    logic               H, M, L;
    logic               Tick;
    logic               Overflow;
    logic               Seco;

    int nCompared   = 0;
    int nMismatched = 0;

    int mLvl;
    int mEdges;
    bit mSh, mSm, mSl, mTick, mOvf, mSeco;

    tanque_sensor_emulador #(
        .LEVEL_W(LEVEL_W), .MAX_LEVEL(MAX_LEVEL), .INIT_LEVEL(INIT_LEVEL),
        .TICK_DIV(TICK_DIV), .FILL_STEP(FILL_STEP), .DRAIN_STEP(DRAIN_STEP),
        .L_TH(L_TH), .M_TH(M_TH), .H_TH(H_TH), .HYST(HYST)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Ve(Ve), .Dreno(Dreno),
        .Fault_Sel(Fault_Sel), .Clr_Flags(Clr_Flags),
        .Level(Level), .H(H), .M(M), .L(L), .Tick(Tick),
        .Overflow(Overflow), .Seco(Seco)
    );

    // Free-running clock, 10 time units per period.
    always #5 Clk = ~Clk;

    function automatic bit probeModel(input int lvl, input int th, input bit cur);
        if (lvl >= th)             return 1'b1;
        else if (lvl < th - HYST)  return 1'b0;
        else                       return cur;
    endfunction

    function automatic logic [2:0] expHml(input logic [1:0] sel);
        logic [2:0] v;
        v = {mSh, mSm, mSl};
        case (sel)
            2'b01:   v[1] = 1'b0;
            2'b10:   v[2] = 1'b1;
            2'b11:   v[0] = 1'b0;
            default: ;
        endcase
        return v;
    endfunction

    // One clock edge: update the tank model from the inputs seen at that edge, then settle.
    task automatic advance();
        int  old;
        int  nxt;
        bit  tk;
        bit  setO;
        bit  setS;
        @(posedge Clk);
        if (!Rst_n) begin
            mEdges = 0;
            mLvl   = INIT_LEVEL;
            mSh = 0; mSm = 0; mSl = 0;
            mTick = 0; mOvf = 0; mSeco = 0;
        end else begin
            old    = mLvl;
            mEdges = mEdges + 1;
            tk     = ((mEdges % TICK_DIV) == 0);
            mSh    = probeModel(old, H_TH, mSh);
            mSm    = probeModel(old, M_TH, mSm);
            mSl    = probeModel(old, L_TH, mSl);
            setO   = tk && Ve && (old == MAX_LEVEL);
            setS   = tk && Dreno && (old == 0);
            if (tk) begin
                nxt = old + FILL_STEP * int'(Ve) - DRAIN_STEP * int'(Dreno);
                if (nxt < 0)         nxt = 0;
                if (nxt > MAX_LEVEL) nxt = MAX_LEVEL;
                mLvl = nxt;
            end
            mOvf  = setO ? 1'b1 : (Clr_Flags ? 1'b0 : mOvf);
            mSeco = setS ? 1'b1 : (Clr_Flags ? 1'b0 : mSeco);
            mTick = tk;
        end
        #1;
    endtask

    // Move the tank to a target level by filling or draining, then close both inputs.
    task automatic driveTo(input int target);
        int budget;
        budget = 3000;
        Ve    = (target > mLvl);
        Dreno = (target < mLvl);
        while (mLvl != target && budget > 0) begin
            advance();
            budget--;
        end
        Ve    = 1'b0;
        Dreno = 1'b0;
        if (mLvl != target) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL driveTo: model level %0d, required %0d", mLvl, target);
        end
    endtask

    // Reset asserted for three cycles in the middle of a fill.
    task automatic test_reset();
        driveTo(100);
        nCompared++;
        if (Level !== 8'd100) begin
            nMismatched++;
            $display("[TB] FAIL reset_pre_level: got %0d, expected 100", Level);
        end
        Ve    = 1'b1;
        Rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            nCompared++;
            if ({Level, H, M, L, Tick, Overflow, Seco} !== {8'd0, 6'b000000}) begin
                nMismatched++;
                $display("[TB] FAIL reset_state: got lvl=%0d hml=%b tick=%b ovf=%b seco=%b, expected 0/000/0/0/0",
                         Level, {H, M, L}, Tick, Overflow, Seco);
            end
        end
        Ve    = 1'b0;
        Rst_n = 1'b1;
    endtask

    // Continuous fill from empty to the clamp, overflow flag, then clearing it.
    task automatic test_fill();
        int budget;
        budget = 1000;
        Ve = 1'b1;
        while (!mOvf && budget > 0) begin
            advance();
            budget--;
            nCompared++;
            if ({Level, H, M, L, Tick} !== {mLvl[7:0], expHml(2'b00), mTick}) begin
                nMismatched++;
                $display("[TB] FAIL fill_track: got lvl=%0d hml=%b tick=%b, expected lvl=%0d hml=%b tick=%b",
                         Level, {H, M, L}, Tick, mLvl, expHml(2'b00), mTick);
            end
        end
        nCompared++;
        if ({Level, H, M, L, Overflow} !== {8'd255, 3'b111, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL fill_overflow: got lvl=%0d hml=%b ovf=%b, expected 255/111/1",
                     Level, {H, M, L}, Overflow);
        end
        Ve        = 1'b0;
        Clr_Flags = 1'b1;
        advance();
        Clr_Flags = 1'b0;
        nCompared++;
        if (Overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fill_clear: got ovf=%b, expected 0", Overflow);
        end
    endtask

    // Draining through the M switch-off window shows the hysteresis.
    task automatic test_hysteresis();
        driveTo(130);
        advance();
        advance();
        nCompared++;
        if ({H, M, L} !== 3'b011) begin
            nMismatched++;
            $display("[TB] FAIL hyst_start: got hml=%b, expected 011", {H, M, L});
        end
        Dreno = 1'b1;
        while (mLvl > 110) begin
            advance();
            nCompared++;
            if ({Level, H, M, L} !== {mLvl[7:0], expHml(2'b00)}) begin
                nMismatched++;
                $display("[TB] FAIL hyst_track: got lvl=%0d hml=%b, expected lvl=%0d hml=%b",
                         Level, {H, M, L}, mLvl, expHml(2'b00));
            end
            if (mLvl >= 120 && mLvl <= 127) begin
                nCompared++;
                if (M !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL hyst_hold: lvl=%0d got M=%b, expected 1", Level, M);
                end
            end
        end
        Dreno = 1'b0;
        advance();
        nCompared++;
        if ({H, M, L} !== 3'b001) begin
            nMismatched++;
            $display("[TB] FAIL hyst_end: got hml=%b, expected 001", {H, M, L});
        end
    endtask

    // Simultaneous fill and drain nets +1; draining an empty tank sets Seco.
    task automatic test_both();
        driveTo(50);
        Ve    = 1'b1;
        Dreno = 1'b1;
        for (int i = 0; i < 3 * TICK_DIV; i++) advance();
        Ve    = 1'b0;
        Dreno = 1'b0;
        nCompared++;
        if (Level !== 8'd53) begin
            nMismatched++;
            $display("[TB] FAIL both_net: got lvl=%0d, expected 53", Level);
        end
        driveTo(0);
        Dreno = 1'b1;
        for (int i = 0; i < 2 * TICK_DIV; i++) advance();
        Dreno = 1'b0;
        nCompared++;
        if ({Level, Seco} !== {8'd0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL dry_seco: got lvl=%0d seco=%b, expected 0/1", Level, Seco);
        end
    endtask

    // Fault overrides appear and disappear without a clock edge.
    task automatic test_faults();
        logic [LEVEL_W-1:0] lvls [3];
        logic [1:0]         sels [3];
        logic [2:0]         want [3];
        lvls = '{8'd130, 8'd70, 8'd200};
        sels = '{2'b11, 2'b10, 2'b01};
        want = '{3'b010, 3'b101, 3'b101};
        for (int i = 0; i < 3; i++) begin
            driveTo(int'(lvls[i]));
            advance();
            advance();
            Fault_Sel = sels[i];
            #1;
            nCompared++;
            if ({H, M, L} !== want[i] || {H, M, L} !== expHml(sels[i])) begin
                nMismatched++;
                $display("[TB] FAIL fault_%0d: lvl=%0d sel=%b got hml=%b, expected %b",
                         i, Level, sels[i], {H, M, L}, want[i]);
            end
            Fault_Sel = 2'b00;
            #1;
            nCompared++;
            if ({H, M, L} !== expHml(2'b00)) begin
                nMismatched++;
                $display("[TB] FAIL fault_restore_%0d: got hml=%b, expected %b",
                         i, {H, M, L}, expHml(2'b00));
            end
        end
    endtask

    // A clear coinciding with the overflow-setting tick loses to the set.
    task automatic test_set_wins();
        int budget;
        driveTo(255);
        budget    = 2 * TICK_DIV;
        Ve        = 1'b1;
        Clr_Flags = 1'b1;
        advance();
        while (!mTick && budget > 0) begin
            advance();
            budget--;
        end
        nCompared++;
        if ({Tick, Overflow} !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL set_wins: got tick=%b ovf=%b, expected 1/1", Tick, Overflow);
        end
        Ve = 1'b0;
        advance();
        Clr_Flags = 1'b0;
        nCompared++;
        if (Overflow !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL set_wins_clear: got ovf=%b, expected 0", Overflow);
        end
    endtask

    // Random inputs, occasional resets, every output compared each cycle.
    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            Ve        = 1'($urandom_range(0, 1));
            Dreno     = 1'($urandom_range(0, 2) == 0);
            Clr_Flags = 1'($urandom_range(0, 15) == 0);
            Fault_Sel = 2'($urandom_range(0, 3));
            Rst_n     = ($urandom_range(0, 299) != 0);
            advance();
            nCompared++;
            if ({Level, H, M, L, Tick, Overflow, Seco} !==
                {mLvl[7:0], expHml(Fault_Sel), mTick, mOvf, mSeco}) begin
                nMismatched++;
                $display("[TB] FAIL random_%0d: got lvl=%0d hml=%b t=%b o=%b s=%b, expected lvl=%0d hml=%b t=%b o=%b s=%b",
                         i, Level, {H, M, L}, Tick, Overflow, Seco,
                         mLvl, expHml(Fault_Sel), mTick, mOvf, mSeco);
            end
        end
        Rst_n     = 1'b1;
        Fault_Sel = 2'b00;
        Clr_Flags = 1'b0;
        Ve        = 1'b0;
        Dreno     = 1'b0;
    endtask

    // Test sequence.
    initial begin
        Rst_n     = 1'b0;
        Ve        = 1'b0;
        Dreno     = 1'b0;
        Fault_Sel = 2'b00;
        Clr_Flags = 1'b0;
        advance();
        advance();
        Rst_n = 1'b1;

        test_reset();
        test_fill();
        test_hysteresis();
        test_both();
        test_faults();
        test_set_wins();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
